// File: rtl/fas_fft_sched.sv
// -----------------------------------------------------------------------------
// fas_fft_sched
//
// Frame scheduler for the FAS FFT path. FIR samples are collected into a
// two-bank (ping-pong) 16-entry frame buffer. Once a bank is full it is handed
// to the 4-stage radix-2 butterfly engine. Each stage is launched as two
// groups of four butterflies, followed by BF_LAT drain cycles. When the last
// stage has drained, fft_valid/ana_start pulse for one cycle and the bank is
// returned to the fill side.
//
// Parameters
//   BF_LAT   butterfly pipeline latency in cycles (1..4)
//   NFRAMES  number of frames in one run
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-low reset
//   fir_valid  one FIR sample present this cycle
//   ana_done   analysis of the latest frame has finished
//   wr_en      write the current FIR sample into the frame buffer
//   wr_bank    bank being filled
//   wr_addr    sample index within the fill bank
//   bf_go      launch four butterflies this cycle
//   bf_bank    bank being transformed
//   bf_stage   FFT stage 0..3
//   bf_grp     butterfly group (0: bfly 0..3, 1: bfly 4..7)
//   fft_valid  one-cycle pulse, spectrum of bf frame is final
//   ana_start  one-cycle pulse, identical to fft_valid
//   frame_cnt  number of fft_valid pulses, saturating at NFRAMES
//   overrun    sticky, a sample was dropped because its bank was busy
//   done       sticky, the complete run has been analysed
// -----------------------------------------------------------------------------
module fas_fft_sched #(
  parameter int BF_LAT  = 2,
  parameter int NFRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       fir_valid,
  input  logic       ana_done,
  output logic       wr_en,
  output logic       wr_bank,
  output logic [3:0] wr_addr,
  output logic       bf_go,
  output logic       bf_bank,
  output logic [1:0] bf_stage,
  output logic       bf_grp,
  output logic       fft_valid,
  output logic       ana_start,
  output logic [6:0] frame_cnt,
  output logic       overrun,
  output logic       done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2,
    S_FIN   = 2'd3
  } state_e;

  localparam logic [1:0] DRAIN_LAST = 2'(BF_LAT - 1);
  localparam logic [6:0] NFR        = 7'(NFRAMES);

  // Registered state
  state_e     state_q,     state_d;
  logic       wr_bank_q,   wr_bank_d;
  logic [3:0] wr_addr_q,   wr_addr_d;
  logic [1:0] pend_q,      pend_d;
  logic [1:0] own_q,       own_d;
  logic [6:0] queued_q,    queued_d;
  logic       bf_go_q,     bf_go_d;
  logic       bf_bank_q,   bf_bank_d;
  logic [1:0] bf_stage_q,  bf_stage_d;
  logic       bf_grp_q,    bf_grp_d;
  logic [1:0] drain_q,     drain_d;
  logic       fin_bank_q,  fin_bank_d;
  logic       fft_valid_q, fft_valid_d;
  logic [6:0] frame_cnt_q, frame_cnt_d;
  logic       overrun_q,   overrun_d;
  logic       done_q,      done_d;

  // Combinational helpers
  logic       release_hit_s;
  logic       fill_owned_s;
  logic       can_take_s;
  logic       wr_en_s;
  logic       drop_s;
  logic       mark_s;
  logic [1:0] mark_vec_s;
  logic [1:0] avail_s;
  logic [1:0] take_s;
  logic       other_bank_s;
  logic       sel_bank_s;

  // Fill side: acceptance, drop detection and the pending mark of a full bank
  always_comb begin
    // A bank being released this cycle (its FIN cycle) already accepts writes.
    release_hit_s = fft_valid_q && (fin_bank_q == wr_bank_q);
    fill_owned_s  = own_q[wr_bank_q] && !release_hit_s;
    can_take_s    = (queued_q < NFR);
    wr_en_s       = fir_valid && !fill_owned_s && can_take_s;
    drop_s        = fir_valid && fill_owned_s && can_take_s;
    mark_s        = wr_en_s && (wr_addr_q == 4'd15);
    if (mark_s) begin
      mark_vec_s = wr_bank_q ? 2'b10 : 2'b01;
    end else begin
      mark_vec_s = 2'b00;
    end
    // A bank completing in this very cycle is already eligible for the engine,
    // so the first bf_go lands in the cycle after the 16th write.
    avail_s      = pend_q | mark_vec_s;
    other_bank_s = ~bf_bank_q;
    if (avail_s[other_bank_s]) begin
      sel_bank_s = other_bank_s;
    end else begin
      sel_bank_s = bf_bank_q;
    end
  end

  // Engine sequencing: next state and next registered engine outputs
  always_comb begin
    state_d     = state_q;
    bf_go_d     = 1'b0;
    bf_bank_d   = bf_bank_q;
    bf_stage_d  = bf_stage_q;
    bf_grp_d    = bf_grp_q;
    drain_d     = drain_q;
    fin_bank_d  = fin_bank_q;
    fft_valid_d = 1'b0;
    take_s      = 2'b00;

    case (state_q)
      S_IDLE: begin
        if (|avail_s) begin
          state_d            = S_ISSUE;
          bf_go_d            = 1'b1;
          bf_bank_d          = sel_bank_s;
          bf_stage_d         = 2'd0;
          bf_grp_d           = 1'b0;
          take_s[sel_bank_s] = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        if (!bf_grp_q) begin
          state_d  = S_ISSUE;
          bf_go_d  = 1'b1;
          bf_grp_d = 1'b1;
        end else begin
          state_d = S_DRAIN;
          drain_d = 2'd0;
        end
      end

      S_DRAIN: begin
        if (drain_q == DRAIN_LAST) begin
          if (bf_stage_q != 2'd3) begin
            state_d    = S_ISSUE;
            bf_go_d    = 1'b1;
            bf_stage_d = bf_stage_q + 2'd1;
            bf_grp_d   = 1'b0;
          end else begin
            state_d     = S_FIN;
            fft_valid_d = 1'b1;
            fin_bank_d  = bf_bank_q;
            // Back-to-back frames: the FIN cycle doubles as stage 0 / grp 0
            // of the other bank when that bank is already waiting.
            if (avail_s[other_bank_s]) begin
              bf_go_d              = 1'b1;
              bf_bank_d            = other_bank_s;
              bf_stage_d           = 2'd0;
              bf_grp_d             = 1'b0;
              take_s[other_bank_s] = 1'b1;
            end else begin
              bf_go_d = 1'b0;
            end
          end
        end else begin
          drain_d = drain_q + 2'd1;
        end
      end

      S_FIN: begin
        if (bf_go_q) begin
          // grp 0 of the next frame already went out during FIN
          state_d  = S_ISSUE;
          bf_go_d  = 1'b1;
          bf_grp_d = 1'b1;
        end else if (|avail_s) begin
          state_d            = S_ISSUE;
          bf_go_d            = 1'b1;
          bf_bank_d          = sel_bank_s;
          bf_stage_d         = 2'd0;
          bf_grp_d           = 1'b0;
          take_s[sel_bank_s] = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Bookkeeping: fill pointer, pending/ownership marks, counters, sticky flags
  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    queued_d  = queued_q;
    if (wr_en_s) begin
      wr_addr_d = wr_addr_q + 4'd1;
    end else begin
      wr_addr_d = wr_addr_q;
    end
    if (mark_s) begin
      wr_bank_d = ~wr_bank_q;
      queued_d  = queued_q + 7'd1;
    end else begin
      wr_bank_d = wr_bank_q;
      queued_d  = queued_q;
    end

    pend_d = (pend_q | mark_vec_s) & ~take_s;

    own_d = own_q;
    if (fft_valid_q) begin
      own_d[fin_bank_q] = 1'b0;
    end else begin
      own_d = own_q;
    end
    own_d = own_d | mark_vec_s;

    if (fft_valid_d && (frame_cnt_q != NFR)) begin
      frame_cnt_d = frame_cnt_q + 7'd1;
    end else begin
      frame_cnt_d = frame_cnt_q;
    end

    overrun_d = overrun_q | drop_s;
    // ana_done only counts once the final frame's pulse has gone by.
    done_d    = done_q | (ana_done && (frame_cnt_q == NFR) && !fft_valid_q);
  end

  // State register with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      wr_bank_q   <= 1'b0;
      wr_addr_q   <= 4'd0;
      pend_q      <= 2'b00;
      own_q       <= 2'b00;
      queued_q    <= 7'd0;
      bf_go_q     <= 1'b0;
      bf_bank_q   <= 1'b0;
      bf_stage_q  <= 2'd0;
      bf_grp_q    <= 1'b0;
      drain_q     <= 2'd0;
      fin_bank_q  <= 1'b0;
      fft_valid_q <= 1'b0;
      frame_cnt_q <= 7'd0;
      overrun_q   <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      wr_addr_q   <= wr_addr_d;
      pend_q      <= pend_d;
      own_q       <= own_d;
      queued_q    <= queued_d;
      bf_go_q     <= bf_go_d;
      bf_bank_q   <= bf_bank_d;
      bf_stage_q  <= bf_stage_d;
      bf_grp_q    <= bf_grp_d;
      drain_q     <= drain_d;
      fin_bank_q  <= fin_bank_d;
      fft_valid_q <= fft_valid_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      done_q      <= done_d;
    end
  end

  // wr_en qualifies the sample present this cycle, so it cannot be registered.
  assign wr_en     = wr_en_s;
  assign wr_bank   = wr_bank_q;
  assign wr_addr   = wr_addr_q;
  assign bf_go     = bf_go_q;
  assign bf_bank   = bf_bank_q;
  assign bf_stage  = bf_stage_q;
  assign bf_grp    = bf_grp_q;
  assign fft_valid = fft_valid_q;
  assign ana_start = fft_valid_q;
  assign frame_cnt = frame_cnt_q;
  assign overrun   = overrun_q;
  assign done      = done_q;

endmodule

// File: tb/tb_fas_fft_sched.sv
// -----------------------------------------------------------------------------
// tb_fas_fft_sched
//
// Two scheduler instances (BF_LAT = 2 and BF_LAT = 4) on one clock and reset.
// A timing model predicts, per driven sample, the expected write, and per
// completed frame, the eight butterfly launches and the fft_valid pulse. These
// are queued and compared as the selected instance produces them.
// -----------------------------------------------------------------------------
module tb_fas_fft_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic fir_in, ana_in, lat4;
  logic fir2, fir4, ana2, ana4;

  logic       wr_en2, wr_bank2, bf_go2, bf_bank2, bf_grp2, fft_valid2, ana_start2, overrun2, done2;
  logic [3:0] wr_addr2;
  logic [1:0] bf_stage2;
  logic [6:0] frame_cnt2;
  logic       wr_en4, wr_bank4, bf_go4, bf_bank4, bf_grp4, fft_valid4, ana_start4, overrun4, done4;
  logic [3:0] wr_addr4;
  logic [1:0] bf_stage4;
  logic [6:0] frame_cnt4;

  assign fir2 = lat4 ? 1'b0 : fir_in;
  assign fir4 = lat4 ? fir_in : 1'b0;
  assign ana2 = lat4 ? 1'b0 : ana_in;
  assign ana4 = lat4 ? ana_in : 1'b0;

  fas_fft_sched #(.BF_LAT(2), .NFRAMES(64)) dut2 (
    .clk(clk), .rst(rst), .fir_valid(fir2), .ana_done(ana2),
    .wr_en(wr_en2), .wr_bank(wr_bank2), .wr_addr(wr_addr2),
    .bf_go(bf_go2), .bf_bank(bf_bank2), .bf_stage(bf_stage2), .bf_grp(bf_grp2),
    .fft_valid(fft_valid2), .ana_start(ana_start2), .frame_cnt(frame_cnt2),
    .overrun(overrun2), .done(done2)
  );

  fas_fft_sched #(.BF_LAT(4), .NFRAMES(64)) dut4 (
    .clk(clk), .rst(rst), .fir_valid(fir4), .ana_done(ana4),
    .wr_en(wr_en4), .wr_bank(wr_bank4), .wr_addr(wr_addr4),
    .bf_go(bf_go4), .bf_bank(bf_bank4), .bf_stage(bf_stage4), .bf_grp(bf_grp4),
    .fft_valid(fft_valid4), .ana_start(ana_start4), .frame_cnt(frame_cnt4),
    .overrun(overrun4), .done(done4)
  );

  // Outputs of the instance under observation
  logic       m_wr_en, m_wr_bank, m_bf_go, m_bf_bank, m_bf_grp, m_fft_valid, m_ana_start, m_overrun, m_done;
  logic [3:0] m_wr_addr;
  logic [1:0] m_bf_stage;
  logic [6:0] m_frame_cnt;
  assign m_wr_en      = lat4 ? wr_en4     : wr_en2;
  assign m_wr_bank    = lat4 ? wr_bank4   : wr_bank2;
  assign m_wr_addr    = lat4 ? wr_addr4   : wr_addr2;
  assign m_bf_go      = lat4 ? bf_go4     : bf_go2;
  assign m_bf_bank    = lat4 ? bf_bank4   : bf_bank2;
  assign m_bf_stage   = lat4 ? bf_stage4  : bf_stage2;
  assign m_bf_grp     = lat4 ? bf_grp4    : bf_grp2;
  assign m_fft_valid  = lat4 ? fft_valid4 : fft_valid2;
  assign m_ana_start  = lat4 ? ana_start4 : ana_start2;
  assign m_frame_cnt  = lat4 ? frame_cnt4 : frame_cnt2;
  assign m_overrun    = lat4 ? overrun4   : overrun2;
  assign m_done       = lat4 ? done4      : done2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct { int cyc; logic bank; logic [3:0] addr; } wr_t;
  typedef struct { int cyc; logic bank; logic [1:0] stage; logic grp; } bf_t;
  typedef struct { int cyc; int fcnt; } fv_t;

  wr_t wr_q[$];
  bf_t bf_q[$];
  fv_t fv_q[$];

  // Model state
  int   m_lat;
  logic m_bank;
  int   m_addr;
  int   m_queued;
  int   m_last_fin;
  int   m_fin[2];
  logic m_own[2];
  int   m_frames;
  logic m_ovr;

  task automatic model_reset();
    wr_q.delete();
    bf_q.delete();
    fv_q.delete();
    m_bank     = 1'b0;
    m_addr     = 0;
    m_queued   = 0;
    m_last_fin = 0;
    m_fin[0]   = 0;
    m_fin[1]   = 0;
    m_own[0]   = 1'b0;
    m_own[1]   = 1'b0;
    m_frames   = 0;
    m_ovr      = 1'b0;
  endtask

  task automatic model_sample(input int t);
    wr_t w;
    bf_t b;
    fv_t f;
    int  start, per, fin;
    if (m_queued >= 64) return;
    if (m_own[m_bank] && (t < m_fin[m_bank])) begin
      m_ovr = 1'b1;
      return;
    end
    w.cyc = t; w.bank = m_bank; w.addr = m_addr[3:0];
    wr_q.push_back(w);
    m_addr++;
    if (m_addr == 16) begin
      start = (t + 1 > m_last_fin) ? t + 1 : m_last_fin;
      per   = 2 + m_lat;
      for (int s = 0; s < 4; s++) begin
        for (int g = 0; g < 2; g++) begin
          b.cyc = start + s * per + g; b.bank = m_bank; b.stage = s[1:0]; b.grp = g[0];
          bf_q.push_back(b);
        end
      end
      fin = start + 4 * per;
      m_frames++;
      f.cyc = fin; f.fcnt = m_frames;
      fv_q.push_back(f);
      m_own[m_bank] = 1'b1;
      m_fin[m_bank] = fin;
      m_last_fin    = fin;
      m_bank        = ~m_bank;
      m_addr        = 0;
      m_queued++;
    end
  endtask

  // Output monitor: pops expectations as the DUT produces events
  wr_t e_wr;
  bf_t e_bf;
  fv_t e_fv;
  always @(negedge clk) begin
    if (rst) begin
      if (m_wr_en) begin
        if (wr_q.size() == 0) chk_eq("wr_unexpected", 32'd1, 32'd0);
        else begin
          e_wr = wr_q.pop_front();
          chk_eq("wr_cycle", cyc, e_wr.cyc);
          chk_eq("wr_bank", {31'd0, m_wr_bank}, {31'd0, e_wr.bank});
          chk_eq("wr_addr", {28'd0, m_wr_addr}, {28'd0, e_wr.addr});
        end
      end
      if (m_bf_go) begin
        if (bf_q.size() == 0) chk_eq("bf_unexpected", 32'd1, 32'd0);
        else begin
          e_bf = bf_q.pop_front();
          chk_eq("bf_cycle", cyc, e_bf.cyc);
          chk_eq("bf_bank", {31'd0, m_bf_bank}, {31'd0, e_bf.bank});
          chk_eq("bf_stage", {30'd0, m_bf_stage}, {30'd0, e_bf.stage});
          chk_eq("bf_grp", {31'd0, m_bf_grp}, {31'd0, e_bf.grp});
        end
      end
      if (m_fft_valid || m_ana_start) begin
        if (fv_q.size() == 0) chk_eq("fv_unexpected", 32'd1, 32'd0);
        else begin
          e_fv = fv_q.pop_front();
          chk_eq("fv_cycle", cyc, e_fv.cyc);
          chk_eq("fv_both", {30'd0, m_fft_valid, m_ana_start}, 32'd3);
          chk_eq("frame_cnt", {25'd0, m_frame_cnt}, e_fv.fcnt);
        end
      end
    end
  end

  // One clock of stimulus; overrun must reflect drops from earlier cycles
  task automatic step(input logic v);
    @(posedge clk);
    #1;
    if (rst) chk_eq("overrun", {31'd0, m_overrun}, {31'd0, m_ovr});
    fir_in = v;
    if (v) model_sample(cyc);
  endtask

  task automatic wait_drain(input int maxc);
    int k = 0;
    while ((wr_q.size() + bf_q.size() + fv_q.size() != 0) && (k < maxc)) begin
      step(1'b0);
      k++;
    end
    chk_eq("drain_left", wr_q.size() + bf_q.size() + fv_q.size(), 32'd0);
  endtask

  // Asserts reset from the current time, checks both instances are all-zero
  task automatic do_reset();
    rst    = 1'b0;
    fir_in = 1'b0;
    ana_in = 1'b0;
    model_reset();
    @(negedge clk);
    chk_eq("rst_outs2", {10'd0, wr_en2, wr_bank2, wr_addr2, bf_go2, bf_bank2, bf_stage2, bf_grp2,
                         fft_valid2, ana_start2, frame_cnt2, overrun2, done2}, 32'd0);
    chk_eq("rst_outs4", {10'd0, wr_en4, wr_bank4, wr_addr4, bf_go4, bf_bank4, bf_stage4, bf_grp4,
                         fft_valid4, ana_start4, frame_cnt4, overrun4, done4}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int k;
    fir_in = 1'b0;
    ana_in = 1'b0;
    lat4   = 1'b0;
    m_lat  = 2;
    rst    = 1'b1;
    #2;
    do_reset();

    // Single frame, then idle until its spectrum is final
    for (int i = 0; i < 16; i++) step(1'b1);
    wait_drain(100);
    chk_eq("single_frame_cnt", {25'd0, frame_cnt2}, 32'd1);

    // Second frame; reset while its first butterfly group is issuing
    for (int i = 0; i < 16; i++) step(1'b1);
    k = 0;
    while (!bf_go2 && (k < 20)) begin
      step(1'b0);
      k++;
    end
    chk_eq("issue2_seen", {31'd0, bf_go2}, 32'd1);
    do_reset();

    // Gapped input: one sample every third cycle, early ana_done ignored
    for (int i = 0; i < 144; i++) begin
      step(i % 3 == 0);
      ana_in = (i == 60);
    end
    ana_in = 1'b0;
    wait_drain(200);
    chk_eq("gap_frame_cnt", {25'd0, frame_cnt2}, 32'd3);
    chk_eq("gap_done", {31'd0, done2}, 32'd0);

    // Full run at BF_LAT = 2, then extra samples that must be ignored
    @(posedge clk);
    #1;
    do_reset();
    for (int i = 0; i < 1034; i++) step(1'b1);
    wait_drain(200);
    chk_eq("run_frame_cnt", {25'd0, frame_cnt2}, 32'd64);
    chk_eq("run_done_before", {31'd0, done2}, 32'd0);
    step(1'b0);
    ana_in = 1'b1;
    step(1'b0);
    ana_in = 1'b0;
    chk_eq("run_done_set", {31'd0, done2}, 32'd1);
    repeat (5) step(1'b0);
    chk_eq("run_done_hold", {31'd0, done2}, 32'd1);

    // Continuous stream at BF_LAT = 4: drops expected, 24-cycle frame spacing
    @(posedge clk);
    #1;
    do_reset();
    lat4  = 1'b1;
    m_lat = 4;
    for (int i = 0; i < 150; i++) step(1'b1);
    wait_drain(300);
    chk_eq("lat4_overrun", {31'd0, overrun4}, 32'd1);
    chk_eq("lat4_frame_cnt", {25'd0, frame_cnt4}, m_frames);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
